// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the CPU load/store to Wishbone bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } bridge_state_t;

  function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
    return ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/wb_mem_bridge_if.sv
// 32-bit point-to-point Wishbone link between the bridge and one peripheral.
interface Wishbone;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        ack;
  logic        err;

  modport Controller (
    output cyc, stb, we, sel, addr, data_wr,
    input  data_rd, ack, err
  );

  modport Peripheral (
    input  cyc, stb, we, sel, addr, data_wr,
    output data_rd, ack, err
  );
endinterface

// File: rtl/wb_mem_bridge_lane_steer.sv
// Byte-lane steering for stores and right-align plus sign/zero extension for loads.
module wb_lane_steer
  import wb_bridge_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic [31:0] data_wr,
  input  logic [1:0]  rd_lo,
  input  logic [1:0]  rd_size,
  input  logic        rd_unsigned,
  input  logic [31:0] data_rd,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    sel     = 4'hF;
    data_wr = wdata;
    case (size)
      SZ_BYTE: begin
        sel     = 4'b0001 << addr_lo;
        data_wr = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        sel     = 4'b0011 << addr_lo;
        data_wr = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = data_rd >> {rd_lo, 3'b000};
    rdata   = shifted;
    case (rd_size)
      SZ_BYTE: rdata = rd_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = rd_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_mem_bridge.sv
// CPU load/store port to single non-pipelined Wishbone transactions, one outstanding at a time.
module wb_mem_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  Wishbone.Controller wb
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TimeoutEn = (TIMEOUT_CYCLES != 0);

  bridge_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d, dwr_q, dwr_d;
  logic        resp_valid_q, resp_valid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  lo_q, lo_d, size_q, size_d;
  logic        uns_q, uns_d;

  logic [3:0]  steer_sel;
  logic [31:0] steer_wr, steer_rd;

  wb_lane_steer u_steer (
    .addr_lo     (req_addr[1:0]),
    .size        (req_size),
    .wdata       (req_wdata),
    .sel         (steer_sel),
    .data_wr     (steer_wr),
    .rd_lo       (lo_q),
    .rd_size     (size_q),
    .rd_unsigned (uns_q),
    .data_rd     (wb.data_rd),
    .rdata       (steer_rd)
  );

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign wb.cyc     = cyc_q;
  assign wb.stb     = cyc_q;
  assign wb.we      = we_q;
  assign wb.sel     = sel_q;
  assign wb.addr    = addr_q;
  assign wb.data_wr = dwr_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    dwr_d        = dwr_q;
    resp_valid_d = resp_valid_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    lo_d         = lo_q;
    size_d       = size_q;
    uns_d        = uns_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if ((req_size == 2'd3) || is_misaligned(req_addr[1:0], req_size)) begin
            // Rejected up front: respond with an error without touching the bus.
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
            state_d      = S_RESP;
          end else begin
            cyc_d   = 1'b1;
            we_d    = req_we;
            addr_d  = {req_addr[31:2], 2'b00};
            sel_d   = steer_sel;
            dwr_d   = steer_wr;
            lo_d    = req_addr[1:0];
            size_d  = req_size;
            uns_d   = req_unsigned;
            cnt_d   = '0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (wb.err || wb.ack || (TimeoutEn && (cnt_q == CntLast))) begin
          // err beats ack; a timeout is only reached when neither is present.
          err_d        = wb.err || !wb.ack;
          rdata_d      = (!wb.err && wb.ack && !we_q) ? steer_rd : 32'h0;
          cyc_d        = 1'b0;
          resp_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          err_d        = 1'b0;
          rdata_d      = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      addr_q       <= '0;
      dwr_q        <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      lo_q         <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      dwr_q        <= dwr_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      lo_q         <= lo_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

endmodule

// File: doc/wb_mem_bridge.md
Name: wb_mem_bridge

Overview:
Converts the CPU load/store port (valid/ready request, valid/ready response) into single non-pipelined Wishbone transactions on a `Wishbone.Controller` modport.
- Sits directly upstream of the Wishbone point-to-point link and feeds it.
- Handles byte-lane steering, load sign/zero extension, misalignment rejection and a bus timeout.
- At most one transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for ack/err before an error response is issued; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned  in  1  load zero-extends when 1
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  bus error, timeout, misaligned access or illegal size
- wb  Wishbone.Controller  —  32-bit bus: cyc, stb, we, sel[3:0], addr, data_wr out; ack, err, data_rd in

Behaviour:
- Reset is asynchronous on rst_n low and forces the following; applying reset mid-transaction abandons the transaction with no response:
  - state = IDLE
  - cyc, stb, we = 0; sel = 0; addr = 0; data_wr = 0
  - resp_valid = 0; resp_rdata = 0; resp_err = 0
  - timeout counter = 0
- All outputs are registered except req_ready, which is (state == IDLE).
- IDLE, on req_valid && req_ready:
  - Legal request → BUS. From the next cycle: cyc = stb = 1, we = req_we, addr = {req_addr[31:2], 2'b00}, sel and data_wr from lane steering.
  - Illegal request (misaligned or size 3) → RESP with resp_err = 1 and rdata = 0. No bus cycle is issued.
- Misaligned means: half with addr[0] = 1, or word with addr[1:0] != 0.
- Lane steering:
  - Byte: sel = 1 << addr[1:0]; data_wr = wdata[7:0] replicated 4×.
  - Half: sel = 4'b0011 << addr[1:0]; data_wr = wdata[15:0] replicated 2×.
  - Word: sel = 4'hF; data_wr = wdata.
- BUS:
  - cyc/stb are held and all outputs stay stable until termination.
  - The counter increments each BUS cycle.
  - err = 1 terminates with resp_err = 1; err wins over a simultaneous ack.
  - Otherwise ack = 1 terminates with resp_err = 0. For loads, data_rd is shifted right by 8·addr[1:0], then masked/extended per size and req_unsigned (latched at accept).
  - Otherwise, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES − 1, terminate with resp_err = 1.
  - Termination drops cyc/stb the next cycle, loads the response registers, asserts resp_valid, enters RESP and clears the counter.
  - Latency: accept at cycle N, cyc rises at N+1, ack at M ≥ N+1, resp_valid at M+1, cyc low at M+1.
- RESP:
  - resp_valid and response fields are held stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid = 0 next cycle → IDLE, so req_ready = 1 that cycle. Back-to-back bus cycles are separated by ≥ 2 idle-cyc cycles.
  - A late ack/err arriving in IDLE or RESP is ignored.
- resp_rdata = 0 for stores and for errors.
- cyc never asserts while resp_valid = 1.

Decomposition:
- Package wb_bridge_pkg holds:
  - typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t
  - typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} bridge_state_t
  - function is_misaligned(addr, size)
- One sub-module, wb_lane_steer (combinational): computes sel/data_wr from (addr[1:0], size, wdata) and extended rdata from (data_rd, addr[1:0], size, unsigned).
- The FSM, counter and registers live in wb_mem_bridge.

Test Plan:
1. Word store, addr 0x1000_0004, wdata 0xDEADBEEF; peripheral acks 2 cycles after stb → sel = 4'hF, addr = 0x1000_0004, we = 1, resp_valid with err = 0 and rdata = 0; cyc rises 1 cycle after accept.
2. Byte load, addr 0x...03, signed, data_rd = 0x80_00_00_00 → sel = 4'b1000, addr low bits = 00, resp_rdata = 0xFFFF_FF80; repeat with unsigned → 0x0000_0080.
3. Half store, addr 0x...02, wdata 0x1234 → sel = 4'b1100, data_wr = 0x1234_1234. Half load at addr 0x...01 → no cyc, resp_err = 1 one cycle after accept.
4. Peripheral never responds, TIMEOUT_CYCLES = 4 → cyc high exactly 4 cycles, then resp_err = 1; a late ack 2 cycles later produces no extra response.
5. ack and err asserted the same cycle → resp_err = 1. With resp_ready held low for 5 cycles, the response is stable, req_ready = 0 and cyc = 0 throughout.
6. rst_n pulsed low mid-BUS → cyc, stb, resp_valid = 0 immediately (async); the next request completes normally.
